// File: rtl/risc16_dmem_arb.sv
// risc16_dmem_arb: shares the data-memory port between the RISC16 core and a
// host requester. The core always wins. Host requests wait in a small FIFO and
// issue only in cycles where the core leaves the memory idle.
module risc16_dmem_arb #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe0,
    input  logic        dwe1,
    output logic [15:0] ddin,
    input  logic        h_valid,
    output logic        h_ready,
    input  logic        h_we,
    input  logic [1:0]  h_be,
    input  logic [15:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_rvalid,
    output logic [15:0] h_rdata,
    output logic        h_busy,
    output logic        starve,
    output logic [15:0] maddr,
    output logic [15:0] mdout,
    input  logic [15:0] mdin,
    output logic        moe,
    output logic        mwe0,
    output logic        mwe1
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t          fifo_q [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          starve_q, starve_d;
    logic          rvalid_q, rvalid_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          cpu_act, fifo_full, fifo_empty, push, pop;

    // Arbitration decision: core first, host head only when the core is idle.
    always_comb begin
        cpu_act    = doe | dwe0 | dwe1;
        fifo_full  = (count_q == (AW + 1)'(DEPTH));
        fifo_empty = (count_q == '0);
        push       = h_valid && !fifo_full && !rst;
        pop        = !cpu_act && !fifo_empty && !rst;
        head       = fifo_q[rd_ptr_q];
    end

    // Memory port mux; idle cycles drive all-zero.
    always_comb begin
        maddr = '0;
        mdout = '0;
        moe   = 1'b0;
        mwe0  = 1'b0;
        mwe1  = 1'b0;
        if (cpu_act) begin
            maddr = daddr;
            mdout = ddout;
            moe   = doe;
            mwe0  = dwe0;
            mwe1  = dwe1;
        end else if (pop) begin
            maddr = head.addr;
            mdout = head.wdata;
            moe   = !head.we;
            mwe0  = head.we & head.be[0];
            mwe1  = head.we & head.be[1];
        end
    end

    // Next-state for FIFO pointers, read response and starvation counter.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        rvalid_d = pop && !head.we;
        rdata_d  = (pop && !head.we) ? mdin : rdata_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (cpu_act && (wait_q != WW'(MAX_WAIT))) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
        starve_d = (wait_d == WW'(MAX_WAIT));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            starve_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{we: h_we, be: h_be, addr: h_addr, wdata: h_wdata};
        end
    end

    // A pulse pending from a read issued just before reset is masked while
    // rst is high, so no stale response ever reaches the host.
    always_comb begin
        ddin     = mdin;
        h_ready  = !fifo_full;
        h_busy   = !fifo_empty;
        h_rvalid = rvalid_q & !rst;
        h_rdata  = rdata_q;
        starve   = starve_q;
    end

endmodule

// File: tb/tb_risc16_dmem_arb.sv
// Directed bench for risc16_dmem_arb with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_risc16_dmem_arb;

    localparam int DEPTH = 4;
    localparam int MAXW  = 4;

    logic        clk, rst;
    logic [15:0] daddr, ddout, ddin, h_addr, h_wdata, h_rdata, maddr, mdout, mdin;
    logic        doe, dwe0, dwe1, h_valid, h_ready, h_we, h_rvalid, h_busy, starve;
    logic        moe, mwe0, mwe1;
    logic [1:0]  h_be;

    int n_checks = 0;
    int n_fail   = 0;

    risc16_dmem_arb #(.DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .daddr(daddr), .ddout(ddout), .doe(doe),
        .dwe0(dwe0), .dwe1(dwe1), .ddin(ddin), .h_valid(h_valid),
        .h_ready(h_ready), .h_we(h_we), .h_be(h_be), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .h_busy(h_busy), .starve(starve), .maddr(maddr), .mdout(mdout),
        .mdin(mdin), .moe(moe), .mwe0(mwe0), .mwe1(mwe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM indexed by address bits [11:4].
    logic [15:0] sram [256];
    assign mdin = sram[maddr[11:4]];
    always @(posedge clk) begin
        if (mwe0) sram[maddr[11:4]][7:0]  <= mdout[7:0];
        if (mwe1) sram[maddr[11:4]][15:8] <= mdout[15:8];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        bit [1:0]    be;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t        mq[$];
    int          mwait;
    bit          m_rv, m_starve, started;
    logic [15:0] m_rd;
    bit          s_rst, s_cpu, s_go, s_hv, s_we;
    logic [1:0]  s_be;
    logic [15:0] s_addr, s_wdata, s_mdin;
    logic [15:0] e_addr, e_dout;
    bit          e_oe, e_w0, e_w1;

    always begin
        @(negedge clk);
        s_rst = rst; s_hv = h_valid; s_we = h_we; s_be = h_be;
        s_addr = h_addr; s_wdata = h_wdata; s_mdin = mdin;
        s_cpu = doe | dwe0 | dwe1;
        s_go  = !s_cpu && (mq.size() > 0) && !s_rst;
        e_addr = 16'h0; e_dout = 16'h0; e_oe = 0; e_w0 = 0; e_w1 = 0;
        if (s_cpu) begin
            e_addr = daddr; e_dout = ddout; e_oe = doe; e_w0 = dwe0; e_w1 = dwe1;
        end else if (s_go) begin
            e_addr = mq[0].addr; e_dout = mq[0].wdata; e_oe = !mq[0].we;
            e_w0 = mq[0].we && mq[0].be[0]; e_w1 = mq[0].we && mq[0].be[1];
        end
        if (started) begin
            chk("maddr", maddr, e_addr);
            chk("mdout", mdout, e_dout);
            chk("moe", 16'(moe), 16'(e_oe));
            chk("mwe0", 16'(mwe0), 16'(e_w0));
            chk("mwe1", 16'(mwe1), 16'(e_w1));
            chk("ddin", ddin, s_mdin);
            chk("h_ready", 16'(h_ready), 16'(mq.size() < DEPTH));
            chk("h_busy", 16'(h_busy), 16'(mq.size() > 0));
            chk("h_rvalid", 16'(h_rvalid), 16'(m_rv && !s_rst));
            chk("h_rdata", h_rdata, m_rd);
            chk("starve", 16'(starve), 16'(m_starve));
        end
        @(posedge clk);
        if (s_rst) begin
            mq.delete(); mwait = 0; m_rv = 0; m_rd = 16'h0; m_starve = 0;
            started = 1;
        end else if (started) begin
            bit acc;
            acc  = s_hv && (mq.size() < DEPTH);
            m_rv = s_go && !mq[0].we;
            if (m_rv) m_rd = s_mdin;
            if (mq.size() == 0 || s_go) mwait = 0;
            else if (s_cpu && mwait < MAXW) mwait++;
            if (s_go) void'(mq.pop_front());
            if (acc) mq.push_back('{we: s_we, be: s_be, addr: s_addr, wdata: s_wdata});
            m_starve = (mwait == MAXW);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input bit we, input logic [1:0] be, input logic [15:0] a, input logic [15:0] d);
        h_valid = 1'b1; h_we = we; h_be = be; h_addr = a; h_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 16'h0;
        sram[8'h04] = 16'h1234;
        sram[8'h10] = 16'hBEEF;
        rst = 1; doe = 0; dwe0 = 0; dwe1 = 0; daddr = 0; ddout = 0;
        h_valid = 0; h_we = 0; h_be = 0; h_addr = 0; h_wdata = 0;
        step(); step();
        #2;
        chk("rst_h_ready", 16'(h_ready), 16'h1);
        chk("rst_h_rvalid", 16'(h_rvalid), 16'h0);
        chk("rst_h_rdata", h_rdata, 16'h0);
        chk("rst_h_busy", 16'(h_busy), 16'h0);
        chk("rst_starve", 16'(starve), 16'h0);
        rst = 0;
        step();

        // Core-only read
        doe = 1; daddr = 16'h0040;
        #2;
        chk("core_maddr", maddr, 16'h0040);
        chk("core_moe", 16'(moe), 16'h1);
        chk("core_ddin", ddin, 16'h1234);
        chk("core_busy", 16'(h_busy), 16'h0);
        step();

        // Host read with idle core
        doe = 0;
        host(0, 2'b00, 16'h0100, 16'h0);
        step();
        h_valid = 0;
        #2;
        chk("hrd_moe", 16'(moe), 16'h1);
        chk("hrd_maddr", maddr, 16'h0100);
        chk("hrd_rvalid_early", 16'(h_rvalid), 16'h0);
        step(); #2;
        chk("hrd_rvalid", 16'(h_rvalid), 16'h1);
        chk("hrd_rdata", h_rdata, 16'hBEEF);
        step(); #2;
        chk("hrd_rvalid_off", 16'(h_rvalid), 16'h0);
        chk("hrd_rdata_hold", h_rdata, 16'hBEEF);
        step();

        // Collision: core stores 3 cycles while a host write waits
        dwe0 = 1; dwe1 = 1; daddr = 16'h0300; ddout = 16'h5555;
        host(1, 2'b01, 16'h0200, 16'h00AA);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("col_maddr", maddr, 16'h0300);
            chk("col_mdout", mdout, 16'h5555);
            step();
            h_valid = 0;
        end
        dwe0 = 0; dwe1 = 0;
        #2;
        chk("col_h_maddr", maddr, 16'h0200);
        chk("col_h_mdout", mdout, 16'h00AA);
        chk("col_h_mwe0", 16'(mwe0), 16'h1);
        chk("col_h_mwe1", 16'(mwe1), 16'h0);
        chk("col_h_busy", 16'(h_busy), 16'h1);
        step(); #2;
        chk("col_busy_fall", 16'(h_busy), 16'h0);
        chk("col_sram_host", sram[8'h20], 16'h00AA);
        chk("col_sram_core", sram[8'h30], 16'h5555);
        step(); step();

        // FIFO full with core continuously active
        doe = 1; daddr = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            host(1, 2'b11, 16'h0500 + 16'(i * 16), 16'hC000 + 16'(i));
            step();
        end
        host(1, 2'b11, 16'h0540, 16'hC004);
        #2; chk("full_ready0", 16'(h_ready), 16'h0);
        step(); #2; chk("full_ready1", 16'(h_ready), 16'h0);
        step();
        doe = 0;
        #2; chk("full_pop_ready", 16'(h_ready), 16'h0);
        step(); #2; chk("full_after_pop_ready", 16'(h_ready), 16'h1);
        step();
        h_valid = 0;
        for (int i = 0; i < 8; i++) step();
        #2;
        chk("full_drained", 16'(h_busy), 16'h0);
        chk("full_sram0", sram[8'h50], 16'hC000);
        chk("full_sram4", sram[8'h54], 16'hC004);
        step();

        // Starvation: one queued request, core busy 10 cycles
        doe = 1;
        host(1, 2'b01, 16'h0600, 16'h0011);
        step();
        h_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            #2; chk("stv_low", 16'(starve), 16'h0);
            step();
        end
        for (int k = 5; k <= 9; k++) begin
            #2; chk("stv_high", 16'(starve), 16'h1);
            step();
        end
        doe = 0;
        #2;
        chk("stv_issue_starve", 16'(starve), 16'h1);
        chk("stv_issue_maddr", maddr, 16'h0600);
        chk("stv_issue_mwe0", 16'(mwe0), 16'h1);
        step(); #2;
        chk("stv_clear", 16'(starve), 16'h0);
        chk("stv_busy", 16'(h_busy), 16'h0);
        step();

        // Reset mid-operation
        doe = 1;
        host(0, 2'b00, 16'h0100, 16'h0000); step();
        host(1, 2'b11, 16'h0700, 16'hC0DE); step();
        host(1, 2'b11, 16'h0710, 16'hFACE); step();
        h_valid = 0;
        doe = 0;
        #2; chk("rmo_read_issue", maddr, 16'h0100);
        step();
        rst = 1;
        host(1, 2'b11, 16'h0720, 16'h7777);
        #2; chk("rmo_rvalid_in_rst", 16'(h_rvalid), 16'h0);
        step();
        rst = 0; h_valid = 0;
        #2;
        chk("rmo_busy", 16'(h_busy), 16'h0);
        chk("rmo_ready", 16'(h_ready), 16'h1);
        chk("rmo_starve", 16'(starve), 16'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rmo_idle_maddr", maddr, 16'h0);
            chk("rmo_idle_en", {13'h0, moe, mwe0, mwe1}, 16'h0);
            chk("rmo_idle_rvalid", 16'(h_rvalid), 16'h0);
            step();
        end
        chk("rmo_sram_untouched", sram[8'h70], 16'h0);
        chk("rmo_sram_discard", sram[8'h72], 16'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
